// File: rtl/vec_mux_rr_sched.sv
// -----------------------------------------------------------------------------
// vec_mux_rr_sched
// Round-robin owner scheduler for the shared 16:1 vector select mux. It drives
// the mux select and a one-hot grant, and qualifies the beat stream sent from
// the mux output to its consumer. An owner keeps the mux until it drops its
// request or until MAX_HOLD beats have been accepted, whichever comes first.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req        in   NREQ per-requester requests (bit i -> mux input i)
//   out_ready  in   consumer accepts the current mux output beat
//   sel        out  SELW registered mux select
//   grant      out  NREQ registered one-hot owner, 0 when idle
//   out_valid  out  combinational: owner is presenting a valid beat
//   busy       out  registered, high while a requester owns the mux
//   beat_cnt   out  CNTW registered beats accepted in the current grant
// -----------------------------------------------------------------------------
module vec_mux_rr_sched #(
  parameter int unsigned NREQ     = 16,
  parameter int unsigned SELW     = 4,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNTW     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            out_ready,
  output logic [SELW-1:0] sel,
  output logic [NREQ-1:0] grant,
  output logic            out_valid,
  output logic            busy,
  output logic [CNTW-1:0] beat_cnt
);

  // Width of a pick result: found flag on top of the selected index.
  localparam int unsigned PICKW = SELW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SELW-1:0]   r_sel;
  logic [SELW-1:0]   w_sel_nxt;
  logic [SELW-1:0]   r_ptr;
  logic [SELW-1:0]   w_ptr_nxt;
  logic [NREQ-1:0]   r_grant;
  logic [NREQ-1:0]   w_grant_nxt;
  logic [CNTW-1:0]   r_cnt;
  logic [CNTW-1:0]   w_cnt_nxt;
  logic              r_busy;
  logic              w_busy_nxt;

  logic [PICKW-1:0]  w_pick_idle;
  logic [PICKW-1:0]  w_pick_rel;
  logic [SELW-1:0]   w_sel_inc;
  logic              w_own_req;
  logic              w_valid;
  logic              w_beat;
  logic              w_last;
  logic              w_release;

  // First requester found scanning start, start+1, ... with modulo wrap.
  // Scanned from the far end so the nearest hit overwrites the result last.
  function automatic logic [PICKW-1:0] pick(input logic [SELW-1:0] start,
                                            input logic [NREQ-1:0] r);
    logic [PICKW-1:0] res;
    logic [SELW-1:0]  idx;
    res = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      idx = start + SELW'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // Arbitration candidates: from the pointer when idle, and from just past
  // the current owner on release so the owner is always considered last.
  assign w_sel_inc   = r_sel + SELW'(1);
  assign w_pick_idle = pick(r_ptr, req);
  assign w_pick_rel  = pick(w_sel_inc, req);

  // Beat qualification; out_ready is irrelevant unless the owner is valid.
  assign w_own_req = req[r_sel];
  assign w_valid   = (r_state == ST_OWN) && w_own_req;
  assign w_beat    = w_valid && out_ready;
  assign w_last    = (r_cnt == CNTW'(MAX_HOLD - 1));
  assign w_release = !w_own_req || (w_beat && w_last);

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;

    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
        if (w_pick_idle[SELW]) begin
          w_state_nxt = ST_OWN;
          w_sel_nxt   = w_pick_idle[SELW-1:0];
          w_grant_nxt = NREQ'(1) << w_pick_idle[SELW-1:0];
        end
      end

      ST_OWN: begin
        if (w_release) begin
          w_ptr_nxt = w_sel_inc;
          w_cnt_nxt = '0;
          if (w_pick_rel[SELW]) begin
            // Hand over directly, no idle cycle between owners.
            w_sel_nxt   = w_pick_rel[SELW-1:0];
            w_grant_nxt = NREQ'(1) << w_pick_rel[SELW-1:0];
          end else begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
          end
        end else if (w_beat) begin
          w_cnt_nxt = r_cnt + CNTW'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt == ST_OWN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign sel       = r_sel;
  assign grant     = r_grant;
  assign busy      = r_busy;
  assign beat_cnt  = r_cnt;
  assign out_valid = w_valid;

endmodule

// File: doc/vec_mux_rr_sched.md
Name: vec_mux_rr_sched

Overview:
Round-robin scheduler that shares the 16:1 vector select mux of the vector CPU among 16 requesters (vector lanes/units).
It drives the mux's 4-bit select and a one-hot grant, and gates a valid/ready beat stream toward the consumer of the mux output.
Each ownership lasts until the owner drops its request or MAX_HOLD beats complete, which guarantees fairness.

Parameters:
NREQ, 16, number of requesters; fixed to match the 4-bit mux select.
SELW, 4, select width; must equal log2(NREQ).
MAX_HOLD, 4, maximum accepted beats per grant; legal range 1..255.
CNTW, 8, beat counter width; must satisfy 2^CNTW > MAX_HOLD.

Ports:
clk     input   1     system clock, rising edge
rst_n   input   1     asynchronous active-low reset
req     input   16    per-requester request; bit i requests mux input i (dat1 = bit 0)
out_ready input 1     consumer accepts the current mux output beat
sel     output  4     registered mux select; drives mux sel
grant   output  16    registered one-hot owner; 0 when idle
out_valid output 1    current mux output is a valid beat
busy    output  1     high while in OWN
beat_cnt output CNTW  beats accepted in the current grant

Behaviour:
- Reset (asynchronous, any state, including mid-grant):
  - state=IDLE, sel=0, grant=0, beat_cnt=0, round-robin pointer ptr=0.
  - out_valid=0, busy=0.
  - Deassertion is synchronised by the normal flop path; the first arbitration happens on the first rising edge after rst_n goes high.
- States: IDLE and OWN.
- Arbitration function pick(ptr, req):
  - Returns the first index i with req[i]=1, scanning ptr, ptr+1, …, 15, 0, …, ptr-1 (mod 16).
  - Returns "none" if req==0.
- IDLE:
  - grant=0, out_valid=0, and sel holds its last value.
  - If req!=0: on the next edge, owner=pick(ptr,req), sel=owner, grant=1<<owner, beat_cnt=0, state=OWN.
  - Arbitration latency is one cycle from req to grant.
- OWN:
  - out_valid = req[sel]; this is combinational from registered sel and live req.
  - beat = out_valid & out_ready.
  - On a beat, beat_cnt increments.
  - out_ready is ignored when out_valid=0.
- Release occurs on an edge when either condition holds:
  - (a) req[sel]=0; or
  - (b) beat occurs and beat_cnt==MAX_HOLD-1.
- On release:
  - ptr = sel+1 mod 16.
  - nxt = pick(sel+1, req) using req sampled that cycle.
  - If nxt exists: sel=nxt, grant=1<<nxt, beat_cnt=0, and state stays OWN. There is no idle bubble between owners.
  - Else: grant=0, beat_cnt=0, state=IDLE.
  - In case (b) the current owner is scanned last, so a sole requester is re-granted to itself back-to-back and beat_cnt restarts at 0.
- Back-pressure: while out_ready=0 the owner, sel and beat_cnt hold indefinitely. There is no timeout.
- Simultaneous events:
  - If the owner drops req in the same cycle its MAX_HOLD beat would complete, no beat occurs (out_valid=0) and release (a) applies.
  - New requests arriving during OWN never preempt the owner.
- sel, grant, busy and beat_cnt are all registered. Only out_valid is combinational.
- Width rule: beat_cnt never exceeds MAX_HOLD-1 while in OWN. It wraps only via a release reset to 0.

Test Plan:
- Reset check: hold rst_n=0 with req=16'hFFFF and out_ready=1.
  - Required: sel=0, grant=0, out_valid=0, busy=0, beat_cnt=0.
  - Then release reset → one cycle later grant=16'h0001, sel=0.
- Sole requester at MAX_HOLD: req=16'h0020 steady, out_ready=1, MAX_HOLD=4.
  - Required: grant=16'h0020 and sel=5 one cycle after req.
  - out_valid=1 each cycle; beat_cnt 0,1,2,3,0,1…
  - Self-regrant with no cycle where grant=0.
- Fair rotation: req=16'h0011 steady, out_ready=1.
  - Required owner sequence: 0 (4 beats), 4 (4 beats), 0 (4 beats), with back-to-back switches and sel 0→4→0.
- Back-pressure: owner=3, out_ready=0 for 10 cycles, req=16'h0108.
  - Required: sel=3, grant=16'h0008, beat_cnt holds.
  - After out_ready=1, four beats complete, then owner becomes 8.
- Request drop and wrap:
  - Owner 7 drops req after 2 beats while req[9] is set → next edge sel=9, beat_cnt=0.
  - Owner 15 releases with req=16'h4004 → next owner 2, not 14.
- Reset mid-operation: assert rst_n=0 while owner=9 and beat_cnt=2.
  - Required: outputs zero immediately without waiting for a clock edge.
  - After release with req=16'h0200 → owner 9 re-granted, with arbitration starting from ptr=0.
